pll_dyn_sequencer: RTL

Reset-and-reconfiguration sequencer for the rPLL used in dynamic-divider mode (DYN_IDIV_SEL/DYN_FBDIV_SEL/DYN_ODIV_SEL = "true"). It runs on the 27 MHz reference clock and owns the PLL's RESET, IDSEL, FBDSEL and ODSEL inputs. It qualifies LOCK and holds the PLL-clocked logic in reset until the PLL has locked and stayed stable. It also accepts run-time frequency-change requests through a valid/ready handshake.

---
 rtl/pll_dyn_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/pll_dyn_sequencer.sv
// Reset/reconfiguration sequencer for an rPLL in dynamic-divider mode.
// It qualifies LOCK, gates the downstream reset and applies divider profiles offered at run time.
module pll_dyn_sequencer #(
  parameter int          RESET_CYCLES = 16,
  parameter int          LOCK_STABLE  = 1024,
  parameter int          LOCK_TIMEOUT = 65536,
  parameter logic [5:0]  DEF_IDSEL    = 6'd0,
  parameter logic [5:0]  DEF_FBDSEL   = 6'd0,
  parameter logic [5:0]  DEF_ODSEL    = 6'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [5:0] cfg_idsel,
  input  logic [5:0] cfg_fbdsel,
  input  logic [5:0] cfg_odsel,
  output logic       pll_reset,
  output logic [5:0] pll_idsel,
  output logic [5:0] pll_fbdsel,
  output logic [5:0] pll_odsel,
  input  logic       pll_lock,
  output logic       user_rst_n,
  output logic       locked,
  output logic       lock_lost,
  output logic       timeout_err,
  output logic [1:0] dbg_state
);

  localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int SW = (LOCK_STABLE  > 1) ? $clog2(LOCK_STABLE)  : 1;
  localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

  localparam logic [RW-1:0] RST_LAST = RW'(RESET_CYCLES - 1);
  localparam logic [SW-1:0] ST_LAST  = SW'(LOCK_STABLE - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RST_PLL   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] rst_cnt_q;
  logic [SW-1:0] st_cnt_q;
  logic [TW-1:0] to_cnt_q;
  logic          lock_meta_q, lock_s_q;
  logic          pll_reset_q, locked_q, user_rst_n_q, cfg_ready_q;
  logic          lock_lost_q, timeout_err_q;
  logic [5:0]    idsel_q, fbdsel_q, odsel_q;

  logic          accept;
  logic          timeout_hit;
  logic          err_d;
  logic          lost_d;

  // Handshake: a profile transfers on a rising clk edge where cfg_valid and
  // cfg_ready are both 1; the requester holds cfg_valid and the selects until then.
  assign accept = cfg_valid & cfg_ready_q;

  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    case (state_q)
      RST_PLL: begin
        if (rst_cnt_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (accept) begin
          state_d = RST_PLL;
        end else if (lock_s_q) begin
          state_d = STABLE;
        end else if (to_cnt_q == TO_LAST) begin
          timeout_hit = 1'b1;
          state_d     = RST_PLL;
        end
      end
      STABLE: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
        end else if (st_cnt_q == ST_LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (accept || !lock_s_q) state_d = RST_PLL;
      end
      default: state_d = RST_PLL;
    endcase
  end

  always_comb begin
    err_d = timeout_err_q;
    if (accept) begin
      err_d = 1'b0;
    end else if (timeout_hit) begin
      err_d = 1'b1;
    end
    lost_d = (state_q == RUN) && !lock_s_q;
  end

  // LOCK from a PLL held in reset is meaningless, so the synchronizer is
  // flushed while pll_reset is high; this also gives the 2-cycle sync latency on every pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else if (pll_reset_q) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock;
      lock_s_q    <= lock_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RST_PLL;
      rst_cnt_q     <= '0;
      st_cnt_q      <= '0;
      to_cnt_q      <= '0;
      pll_reset_q   <= 1'b1;
      locked_q      <= 1'b0;
      user_rst_n_q  <= 1'b0;
      cfg_ready_q   <= 1'b0;
      lock_lost_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      idsel_q       <= DEF_IDSEL;
      fbdsel_q      <= DEF_FBDSEL;
      odsel_q       <= DEF_ODSEL;
    end else begin
      state_q <= state_d;
      // Each counter runs only while its state persists; any transition clears it.
      rst_cnt_q <= (state_q == RST_PLL && state_d == RST_PLL) ? rst_cnt_q + 1'b1 : '0;
      to_cnt_q  <= (state_q == WAIT_LOCK && state_d == WAIT_LOCK) ? to_cnt_q + 1'b1 : '0;
      st_cnt_q  <= (state_q == STABLE && state_d == STABLE) ? st_cnt_q + 1'b1 : '0;
      pll_reset_q   <= (state_d == RST_PLL);
      locked_q      <= (state_d == RUN);
      user_rst_n_q  <= (state_d == RUN);
      cfg_ready_q   <= (state_d == RUN) || ((state_d == WAIT_LOCK) && err_d);
      lock_lost_q   <= lost_d;
      timeout_err_q <= err_d;
      if (accept) begin
        idsel_q  <= cfg_idsel;
        fbdsel_q <= cfg_fbdsel;
        odsel_q  <= cfg_odsel;
      end
    end
  end

  assign cfg_ready   = cfg_ready_q;
  assign pll_reset   = pll_reset_q;
  assign pll_idsel   = idsel_q;
  assign pll_fbdsel  = fbdsel_q;
  assign pll_odsel   = odsel_q;
  assign user_rst_n  = user_rst_n_q;
  assign locked      = locked_q;
  assign lock_lost   = lock_lost_q;
  assign timeout_err = timeout_err_q;
  assign dbg_state   = state_q;

endmodule
